qos_ctrl_fsm: RTL and testbench

//  Main control FSM of the PCIe QoS module: the receiving end of the FSM stimulus interface.

---
 rtl/qos_ctrl_fsm_pkg.sv | 15 +
 rtl/qos_ctrl_fsm_pause_tracker.sv | 25 ++
 rtl/qos_ctrl_fsm.sv | 134 +++++++++++++
 tb/tb_qos_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_ctrl_fsm_pkg.sv
// Shared definitions for the PCIe QoS control FSM: state codes and state width.
package qos_ctrl_fsm_pkg;

  localparam int ST_W = 3;

  // Codes 5..7 are unused and treated as illegal by the FSM.
  typedef enum logic [ST_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/qos_ctrl_fsm_pause_tracker.sv
// Per-channel pause register: resume clears a bit, pause sets it, otherwise it holds.
module qos_pause_tracker #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  input  logic [NCH-1:0] pause,
  input  logic [NCH-1:0] resume,
  output logic [NCH-1:0] mask
);

  // Sync clear has priority over update; resume beats pause on the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (clr) begin
      mask <= '0;
    end else if (en) begin
      mask <= (mask | pause) & ~resume;
    end
  end

endmodule

// File: rtl/qos_ctrl_fsm.sv
// Main control FSM of the PCIe QoS block: sequences RESET->INIT->IDLE/ACTIVE,
// latches FIFO thresholds, tracks per-channel pause and traps overflow in ERROR.
module qos_ctrl_fsm
  import qos_ctrl_fsm_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int TH_W = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            set_init,
  input  logic [TH_W-1:0] init_low_th,
  input  logic [TH_W-1:0] init_high_th,
  input  logic [NCH-1:0]  empty,
  input  logic [NCH-1:0]  full,
  input  logic [NCH-1:0]  Pause,
  input  logic [NCH-1:0]  Continue,
  output logic [ST_W-1:0] state,
  output logic            init_out,
  output logic            idle_out,
  output logic            active_out,
  output logic            error_out,
  output logic [NCH-1:0]  error_full,
  output logic [NCH-1:0]  pause_mask,
  output logic [TH_W-1:0] low_th,
  output logic [TH_W-1:0] high_th
);

  state_t         state_q;
  state_t         state_d;
  logic           err_load;
  logic [NCH-1:0] err_val;
  logic           pause_en;
  logic           pause_clr;

  assign state = state_q;

  // Next-state decode; full has priority over set_init, which beats FIFO activity.
  always_comb begin
    state_d  = state_q;
    err_load = 1'b0;
    err_val  = '0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!set_init) begin
          if (init_low_th < init_high_th) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_ERROR;
            err_load = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (|full) begin
          state_d  = ST_ERROR;
          err_load = 1'b1;
          err_val  = full;
        end else if (set_init) begin
          state_d = ST_INIT;
        end else if (~&empty) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (|full) begin
          state_d  = ST_ERROR;
          err_load = 1'b1;
          err_val  = full;
        end else if (set_init) begin
          state_d = ST_INIT;
        end else if (&empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  // State register with one-hot flags registered from the next state so both change together.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      init_out   <= 1'b0;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_out   <= (state_d == ST_INIT);
      idle_out   <= (state_d == ST_IDLE);
      active_out <= (state_d == ST_ACTIVE);
      error_out  <= (state_d == ST_ERROR);
    end
  end

  // Threshold latch: follows the init inputs while in INIT, frozen elsewhere.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      low_th  <= '0;
      high_th <= '0;
    end else if (state_q == ST_INIT) begin
      low_th  <= init_low_th;
      high_th <= init_high_th;
    end
  end

  // Error capture: full vector on overflow entry, zero for a threshold error.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      error_full <= '0;
    end else if (err_load) begin
      error_full <= err_val;
    end
  end

  assign pause_en  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign pause_clr = (state_q == ST_RESET) || (state_q == ST_INIT);

  qos_pause_tracker #(
    .NCH(NCH)
  ) u_pause (
    .clk   (CLK),
    .rst   (reset),
    .en    (pause_en),
    .clr   (pause_clr),
    .pause (Pause),
    .resume(Continue),
    .mask  (pause_mask)
  );

endmodule

// File: tb/tb_qos_ctrl_fsm.sv
// Directed bench for qos_ctrl_fsm: one task per scenario, inline checks.
module tb_qos_ctrl_fsm;
  import qos_ctrl_fsm_pkg::*;

  localparam int NCH  = 4;
  localparam int TH_W = 4;

  logic            CLK = 1'b0;
  logic            reset;
  logic            set_init;
  logic [TH_W-1:0] init_low_th;
  logic [TH_W-1:0] init_high_th;
  logic [NCH-1:0]  empty;
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  Pause;
  logic [NCH-1:0]  Continue;
  logic [2:0]      state;
  logic            init_out;
  logic            idle_out;
  logic            active_out;
  logic            error_out;
  logic [NCH-1:0]  error_full;
  logic [NCH-1:0]  pause_mask;
  logic [TH_W-1:0] low_th;
  logic [TH_W-1:0] high_th;

  int total = 0;
  int bad   = 0;

  qos_ctrl_fsm #(.NCH(NCH), .TH_W(TH_W)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .set_init    (set_init),
    .init_low_th (init_low_th),
    .init_high_th(init_high_th),
    .empty       (empty),
    .full        (full),
    .Pause       (Pause),
    .Continue    (Continue),
    .state       (state),
    .init_out    (init_out),
    .idle_out    (idle_out),
    .active_out  (active_out),
    .error_out   (error_out),
    .error_full  (error_full),
    .pause_mask  (pause_mask),
    .low_th      (low_th),
    .high_th     (high_th)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected flag vector {init,idle,active,error} for a state code.
  function automatic logic [3:0] flags_for(input logic [2:0] s);
    case (s)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; set_init = 1'b1; init_low_th = 4'd3; init_high_th = 4'd12;
    empty = 4'hF; full = 4'h0; Pause = 4'h0; Continue = 4'h0;
    #13;
    total++;
    if ({state, init_out, idle_out, active_out, error_out, error_full, pause_mask, low_th, high_th} !== 23'd0) begin
      bad++;
      $display("FAIL reset_vals state=%0d flags=%b ef=%h pm=%h lo=%0d hi=%0d expected all 0",
               state, {init_out, idle_out, active_out, error_out}, error_full, pause_mask, low_th, high_th);
    end
    #1 reset = 1'b0;
    step();
    total++;
    if (state !== 3'd1 || {init_out, idle_out, active_out, error_out} !== flags_for(3'd1)) begin
      bad++;
      $display("FAIL enter_init state=%0d flags=%b expected 1/1000", state, {init_out, idle_out, active_out, error_out});
    end
    step();
    total++;
    if (low_th !== 4'd3 || high_th !== 4'd12) begin
      bad++;
      $display("FAIL init_thresh lo=%0d hi=%0d expected 3/12", low_th, high_th);
    end
  endtask

  task automatic test_idle_active();
    set_init = 1'b0;
    step();
    total++;
    if (state !== 3'd2 || {init_out, idle_out, active_out, error_out} !== flags_for(3'd2)) begin
      bad++;
      $display("FAIL init_to_idle state=%0d flags=%b expected 2/0100", state, {init_out, idle_out, active_out, error_out});
    end
    empty = 4'h0;
    step();
    total++;
    if (state !== 3'd3 || {init_out, idle_out, active_out, error_out} !== flags_for(3'd3)) begin
      bad++;
      $display("FAIL idle_to_active state=%0d flags=%b expected 3/0010", state, {init_out, idle_out, active_out, error_out});
    end
    empty = 4'hF;
    step();
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL active_to_idle state=%0d expected 2", state);
    end
    empty = 4'h0;
    step();
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL reactivate state=%0d expected 3", state);
    end
  endtask

  task automatic test_pause();
    Pause = 4'b0110; Continue = 4'b0000;
    step();
    total++;
    if (pause_mask !== 4'b0110) begin
      bad++;
      $display("FAIL pause_set mask=%b expected 0110", pause_mask);
    end
    Continue = 4'b0100;
    step();
    total++;
    if (pause_mask !== 4'b0010) begin
      bad++;
      $display("FAIL continue_wins mask=%b expected 0010", pause_mask);
    end
    Pause = 4'b0000; Continue = 4'b1010;
    step();
    total++;
    if (pause_mask !== 4'b0000) begin
      bad++;
      $display("FAIL continue_clear mask=%b expected 0000", pause_mask);
    end
    Pause = 4'b1000; Continue = 4'b0000;
    step();
    Pause = 4'b0000; empty = 4'hF;
    step();
    total++;
    if (state !== 3'd2 || pause_mask !== 4'b1000) begin
      bad++;
      $display("FAIL pause_hold_idle state=%0d mask=%b expected 2/1000", state, pause_mask);
    end
    empty = 4'h0;
    step();
    total++;
    if (state !== 3'd3 || pause_mask !== 4'b1000) begin
      bad++;
      $display("FAIL pause_hold_active state=%0d mask=%b expected 3/1000", state, pause_mask);
    end
  endtask

  task automatic test_overflow_error();
    full = 4'd4;
    step();
    total++;
    if (state !== 3'd4 || error_full !== 4'b0100 || {init_out, idle_out, active_out, error_out} !== flags_for(3'd4)) begin
      bad++;
      $display("FAIL overflow state=%0d ef=%b flags=%b expected 4/0100/0001",
               state, error_full, {init_out, idle_out, active_out, error_out});
    end
    set_init = 1'b1; full = 4'h0; Continue = 4'hF; Pause = 4'h1; init_low_th = 4'd7;
    step();
    step();
    total++;
    if (state !== 3'd4 || error_full !== 4'b0100 || pause_mask !== 4'b1000 || low_th !== 4'd3) begin
      bad++;
      $display("FAIL error_sticky state=%0d ef=%b mask=%b lo=%0d expected 4/0100/1000/3",
               state, error_full, pause_mask, low_th);
    end
    Continue = 4'h0; Pause = 4'h0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({state, init_out, idle_out, active_out, error_out, error_full, pause_mask, low_th, high_th} !== 23'd0) begin
      bad++;
      $display("FAIL async_reset state=%0d flags=%b ef=%h pm=%h lo=%0d hi=%0d expected all 0",
               state, {init_out, idle_out, active_out, error_out}, error_full, pause_mask, low_th, high_th);
    end
  endtask

  task automatic test_threshold_error();
    set_init = 1'b1; init_low_th = 4'd9; init_high_th = 4'd9; empty = 4'hF; full = 4'h0;
    @(negedge CLK);
    reset = 1'b0;
    step();
    step();
    set_init = 1'b0;
    step();
    total++;
    if (state !== 3'd4 || error_out !== 1'b1 || error_full !== 4'b0000 || high_th !== 4'd9 || low_th !== 4'd9) begin
      bad++;
      $display("FAIL thresh_error state=%0d err=%b ef=%b lo=%0d hi=%0d expected 4/1/0000/9/9",
               state, error_out, error_full, low_th, high_th);
    end
  endtask

  task automatic test_full_priority_illegal();
    reset = 1'b1;
    set_init = 1'b1; init_low_th = 4'd3; init_high_th = 4'd12; empty = 4'hF; full = 4'h0;
    @(negedge CLK);
    reset = 1'b0;
    step();
    step();
    set_init = 1'b0;
    step();
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL reach_idle state=%0d expected 2", state);
    end
    full = 4'b0001; set_init = 1'b1;
    step();
    total++;
    if (state !== 3'd4 || error_full !== 4'b0001) begin
      bad++;
      $display("FAIL full_wins state=%0d ef=%b expected 4/0001", state, error_full);
    end
    full = 4'h0; set_init = 1'b0;
    force dut.state_q = state_t'(3'd6);
    #1 release dut.state_q;
    total++;
    if (state !== 3'd6) begin
      bad++;
      $display("FAIL force_illegal state=%0d expected 6", state);
    end
    step();
    total++;
    if (state !== 3'd0 || {init_out, idle_out, active_out, error_out} !== 4'b0000) begin
      bad++;
      $display("FAIL illegal_recover state=%0d flags=%b expected 0/0000", state, {init_out, idle_out, active_out, error_out});
    end
    step();
    total++;
    if (state !== 3'd1 || init_out !== 1'b1) begin
      bad++;
      $display("FAIL illegal_to_init state=%0d init=%b expected 1/1", state, init_out);
    end
  endtask

  initial begin
    test_reset();
    test_idle_active();
    test_pause();
    test_overflow_error();
    test_threshold_error();
    test_full_priority_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
